// File: rtl/io_port_endpoint.sv
// Device-side endpoint for one Datapath I/O port: an inbound FIFO presented to
// the Datapath as a readable port and an outbound FIFO drained over valid/ready.

module io_port_fifo #(
  parameter int unsigned WORD_WIDTH  = 36,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned DEPTH_WIDTH = 2,
  parameter string       RAMSTYLE    = "MLAB"
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WORD_WIDTH-1:0]  push_data,
  input  logic                   pop,
  output logic                   empty,
  output logic                   full,
  output logic [WORD_WIDTH-1:0]  head,
  output logic [DEPTH_WIDTH:0]   count
);

  localparam int unsigned PTR_WIDTH = DEPTH_WIDTH + 1;

  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  wr_ptr_next;
  logic [PTR_WIDTH-1:0]  rd_ptr_next;
  logic                  do_push;
  logic                  do_pop;

  (* ramstyle = RAMSTYLE *) logic [WORD_WIDTH-1:0] mem [DEPTH];

  // Wrap bit in the pointer MSB separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_WIDTH-1:0] == rd_ptr[DEPTH_WIDTH-1:0]) &&
                 (wr_ptr[DEPTH_WIDTH] != rd_ptr[DEPTH_WIDTH]);

  // Flags come from pre-edge state, so there is no full- or empty-bypass.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (do_push) wr_ptr_next = wr_ptr + PTR_WIDTH'(1);
    if (do_pop)  rd_ptr_next = rd_ptr + PTR_WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= wr_ptr_next - rd_ptr_next;
    end
  end

  // Storage is not reset; the head is masked while empty so outputs stay X-free.
  always_ff @(posedge clock) begin
    if (reset_n && do_push) mem[wr_ptr[DEPTH_WIDTH-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr[DEPTH_WIDTH-1:0]];

endmodule

module io_port_endpoint #(
  parameter int unsigned WORD_WIDTH  = 36,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned DEPTH_WIDTH = 2,
  parameter string       RAMSTYLE    = "MLAB"
) (
  input  logic                   clock,
  input  logic                   reset_n,
  output logic                   io_read_EF,
  output logic [WORD_WIDTH-1:0]  io_read_data,
  input  logic                   io_rden,
  output logic                   io_write_EF,
  input  logic [WORD_WIDTH-1:0]  io_write_data,
  input  logic                   io_wren,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_WIDTH-1:0]  out_data,
  output logic [DEPTH_WIDTH:0]   in_count,
  output logic [DEPTH_WIDTH:0]   out_count,
  output logic                   read_underflow,
  output logic                   write_overflow
);

  logic in_empty;
  logic in_full;
  logic out_empty;
  logic out_full;

  // Producer -> Datapath.
  io_port_fifo #(
    .WORD_WIDTH  (WORD_WIDTH),
    .DEPTH       (DEPTH),
    .DEPTH_WIDTH (DEPTH_WIDTH),
    .RAMSTYLE    (RAMSTYLE)
  ) u_inbound (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (io_rden),
    .empty     (in_empty),
    .full      (in_full),
    .head      (io_read_data),
    .count     (in_count)
  );

  // Datapath -> consumer.
  io_port_fifo #(
    .WORD_WIDTH  (WORD_WIDTH),
    .DEPTH       (DEPTH),
    .DEPTH_WIDTH (DEPTH_WIDTH),
    .RAMSTYLE    (RAMSTYLE)
  ) u_outbound (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (io_wren),
    .push_data (io_write_data),
    .pop       (out_ready),
    .empty     (out_empty),
    .full      (out_full),
    .head      (out_data),
    .count     (out_count)
  );

  assign io_read_EF  = ~in_empty;
  assign in_ready    = ~in_full;
  assign io_write_EF = out_full;
  assign out_valid   = ~out_empty;

  // Protocol violations latch until reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      read_underflow <= 1'b0;
      write_overflow <= 1'b0;
    end else begin
      if (io_rden && in_empty) read_underflow <= 1'b1;
      if (io_wren && out_full) write_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_port_endpoint.sv
// Self-checking bench for io_port_endpoint: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.

module tb_io_port_endpoint;

  localparam int unsigned W  = 36;
  localparam int unsigned D  = 4;
  localparam int unsigned DW = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          io_read_EF;
  logic [W-1:0]  io_read_data;
  logic          io_rden;
  logic          io_write_EF;
  logic [W-1:0]  io_write_data;
  logic          io_wren;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [DW:0]   in_count;
  logic [DW:0]   out_count;
  logic          read_underflow;
  logic          write_overflow;

  always #5 clock = ~clock;

  io_port_endpoint #(
    .WORD_WIDTH  (W),
    .DEPTH       (D),
    .DEPTH_WIDTH (DW),
    .RAMSTYLE    ("MLAB")
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .io_read_EF     (io_read_EF),
    .io_read_data   (io_read_data),
    .io_rden        (io_rden),
    .io_write_EF    (io_write_EF),
    .io_write_data  (io_write_data),
    .io_wren        (io_wren),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .in_count       (in_count),
    .out_count      (out_count),
    .read_underflow (read_underflow),
    .write_overflow (write_overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid      = 1'b0;
    in_data       = '0;
    io_rden       = 1'b0;
    io_wren       = 1'b0;
    io_write_data = '0;
    out_ready     = 1'b0;
  endtask

  task automatic chk_empty_state(input string tag);
    chk({tag, " in_count"},       64'(in_count),       64'd0);
    chk({tag, " out_count"},      64'(out_count),      64'd0);
    chk({tag, " io_read_EF"},     64'(io_read_EF),     64'd0);
    chk({tag, " io_write_EF"},    64'(io_write_EF),    64'd0);
    chk({tag, " in_ready"},       64'(in_ready),       64'd1);
    chk({tag, " out_valid"},      64'(out_valid),      64'd0);
    chk({tag, " io_read_data"},   64'(io_read_data),   64'd0);
    chk({tag, " out_data"},       64'(out_data),       64'd0);
    chk({tag, " read_underflow"}, 64'(read_underflow), 64'd0);
    chk({tag, " write_overflow"}, 64'(write_overflow), 64'd0);
  endtask

  typedef struct {
    logic          iv;
    logic [W-1:0]  id;
    logic          rd;
    logic          wv;
    logic [W-1:0]  wd;
    logic          ordy;
    logic [DW:0]   e_inc;
    logic          e_ref;
    logic [W-1:0]  e_rdata;
    logic [DW:0]   e_outc;
    logic          e_ov;
    logic [W-1:0]  e_odata;
  } vec_t;

  vec_t tbl [6];

  // Reference model state
  logic [W-1:0] mq_in  [$];
  logic [W-1:0] mq_out [$];
  logic         m_uf;
  logic         m_ov;

  initial begin
    // Inbound ordering 1,2,3 alongside outbound streaming 4,5,6
    tbl[0] = '{1'b1, 36'd1, 1'b0, 1'b1, 36'd4, 1'b1, 3'd1, 1'b1, 36'd1, 3'd1, 1'b1, 36'd4};
    tbl[1] = '{1'b1, 36'd2, 1'b0, 1'b1, 36'd5, 1'b1, 3'd2, 1'b1, 36'd1, 3'd1, 1'b1, 36'd5};
    tbl[2] = '{1'b1, 36'd3, 1'b0, 1'b1, 36'd6, 1'b1, 3'd3, 1'b1, 36'd1, 3'd1, 1'b1, 36'd6};
    tbl[3] = '{1'b0, 36'd0, 1'b1, 1'b0, 36'd0, 1'b1, 3'd2, 1'b1, 36'd2, 3'd0, 1'b0, 36'd0};
    tbl[4] = '{1'b0, 36'd0, 1'b1, 1'b0, 36'd0, 1'b1, 3'd1, 1'b1, 36'd3, 3'd0, 1'b0, 36'd0};
    tbl[5] = '{1'b0, 36'd0, 1'b1, 1'b0, 36'd0, 1'b1, 3'd0, 1'b0, 36'd0, 3'd0, 1'b0, 36'd0};

    // Reset held 2 cycles with traffic offered
    idle();
    reset_n       = 1'b0;
    in_valid      = 1'b1;
    in_data       = 36'd99;
    io_wren       = 1'b1;
    io_write_data = 36'd98;
    repeat (2) tick();
    chk_empty_state("reset");
    idle();
    reset_n = 1'b1;

    // Vector table
    for (int i = 0; i < 6; i++) begin
      in_valid      = tbl[i].iv;
      in_data       = tbl[i].id;
      io_rden       = tbl[i].rd;
      io_wren       = tbl[i].wv;
      io_write_data = tbl[i].wd;
      out_ready     = tbl[i].ordy;
      tick();
      chk($sformatf("vec%0d in_count", i),     64'(in_count),     64'(tbl[i].e_inc));
      chk($sformatf("vec%0d io_read_EF", i),   64'(io_read_EF),   64'(tbl[i].e_ref));
      chk($sformatf("vec%0d io_read_data", i), 64'(io_read_data), 64'(tbl[i].e_rdata));
      chk($sformatf("vec%0d out_count", i),    64'(out_count),    64'(tbl[i].e_outc));
      chk($sformatf("vec%0d out_valid", i),    64'(out_valid),    64'(tbl[i].e_ov));
      chk($sformatf("vec%0d out_data", i),     64'(out_data),     64'(tbl[i].e_odata));
    end
    idle();
    chk("vec sticky ru", 64'(read_underflow), 64'd0);
    chk("vec sticky wo", 64'(write_overflow), 64'd0);

    // Fill inbound with 10..14; 14 must be refused
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = W'(10 + k);
      tick();
      chk($sformatf("fill in_count %0d", k), 64'(in_count), 64'((k < 4) ? k + 1 : 4));
      chk($sformatf("fill in_ready %0d", k), 64'(in_ready), 64'((k < 3) ? 1 : 0));
    end
    in_valid = 1'b0;
    io_rden  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain data %0d", k), 64'(io_read_data), 64'(10 + k));
      tick();
    end
    io_rden = 1'b0;
    chk("drain in_count", 64'(in_count), 64'd0);
    chk("drain io_read_EF", 64'(io_read_EF), 64'd0);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = W'(20 + k);
      tick();
    end
    in_valid = 1'b0;
    chk("wrap in_count", 64'(in_count), 64'd4);
    io_rden = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap data %0d", k), 64'(io_read_data), 64'(20 + k));
      tick();
    end
    io_rden = 1'b0;
    chk("wrap empty", 64'(io_read_EF), 64'd0);
    chk("wrap ru", 64'(read_underflow), 64'd0);

    // Outbound full with simultaneous pop and write
    io_wren = 1'b1;
    for (int k = 0; k < 4; k++) begin
      io_write_data = W'(100 + k);
      tick();
    end
    chk("ofull out_count", 64'(out_count), 64'd4);
    chk("ofull io_write_EF", 64'(io_write_EF), 64'd1);
    io_write_data = 36'd200;
    out_ready     = 1'b1;
    chk("ofull head", 64'(out_data), 64'd100);
    tick();
    chk("osim out_count", 64'(out_count), 64'd3);
    chk("osim write_overflow", 64'(write_overflow), 64'd1);
    chk("osim io_write_EF", 64'(io_write_EF), 64'd0);
    io_write_data = 36'd201;
    out_ready     = 1'b0;
    tick();
    chk("oafter out_count", 64'(out_count), 64'd4);
    io_wren   = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("odrain data %0d", k), 64'(out_data), 64'((k < 3) ? 101 + k : 201));
      tick();
    end
    idle();
    chk("odrain out_valid", 64'(out_valid), 64'd0);
    chk("odrain wo sticky", 64'(write_overflow), 64'd1);

    // Reset mid-transfer drops stored words and sticky bits
    in_valid = 1'b1;
    in_data  = 36'd55;
    io_wren  = 1'b1;
    io_write_data = 36'd66;
    tick();
    reset_n = 1'b0;
    tick();
    idle();
    reset_n = 1'b1;
    chk_empty_state("midreset");

    // Empty inbound: pop and push together
    io_rden  = 1'b1;
    in_valid = 1'b1;
    in_data  = 36'd7;
    tick();
    idle();
    chk("esim read_underflow", 64'(read_underflow), 64'd1);
    chk("esim in_count", 64'(in_count), 64'd1);
    chk("esim io_read_EF", 64'(io_read_EF), 64'd1);
    chk("esim io_read_data", 64'(io_read_data), 64'd7);

    // Randomized traffic against the queue model
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    mq_in.delete();
    mq_out.delete();
    m_uf = 1'b0;
    m_ov = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int unsigned bias_in;
      int unsigned bias_out;
      logic        do_rst;
      logic        in_full_m;
      logic        out_full_m;
      logic        in_ef_m;
      logic        out_ne_m;
      bias_in  = ((c / 200) % 2 == 0) ? 3 : 1;
      bias_out = ((c / 300) % 2 == 0) ? 1 : 3;
      do_rst        = ($urandom_range(0, 199) == 0);
      reset_n       = ~do_rst;
      in_valid      = ($urandom_range(0, 3) < bias_in);
      in_data       = W'({$urandom(), $urandom()});
      io_rden       = ($urandom_range(0, 3) >= bias_in);
      io_wren       = ($urandom_range(0, 3) < bias_out);
      io_write_data = W'({$urandom(), $urandom()});
      out_ready     = ($urandom_range(0, 3) >= bias_out);
      in_full_m  = (mq_in.size() == D);
      out_full_m = (mq_out.size() == D);
      in_ef_m    = (mq_in.size() != 0);
      out_ne_m   = (mq_out.size() != 0);
      if (do_rst) begin
        mq_in.delete();
        mq_out.delete();
        m_uf = 1'b0;
        m_ov = 1'b0;
      end else begin
        if (io_rden && !in_ef_m) m_uf = 1'b1;
        if (io_wren && out_full_m) m_ov = 1'b1;
        if (io_rden && in_ef_m) void'(mq_in.pop_front());
        if (in_valid && !in_full_m) mq_in.push_back(in_data);
        if (out_ready && out_ne_m) void'(mq_out.pop_front());
        if (io_wren && !out_full_m) mq_out.push_back(io_write_data);
      end
      tick();
      chk("rnd in_count",     64'(in_count),     64'(mq_in.size()));
      chk("rnd out_count",    64'(out_count),    64'(mq_out.size()));
      chk("rnd io_read_EF",   64'(io_read_EF),   64'(mq_in.size() != 0));
      chk("rnd in_ready",     64'(in_ready),     64'(mq_in.size() != D));
      chk("rnd io_write_EF",  64'(io_write_EF),  64'(mq_out.size() == D));
      chk("rnd out_valid",    64'(out_valid),    64'(mq_out.size() != 0));
      chk("rnd io_read_data", 64'(io_read_data), 64'((mq_in.size() != 0) ? mq_in[0] : '0));
      chk("rnd out_data",     64'(out_data),     64'((mq_out.size() != 0) ? mq_out[0] : '0));
      chk("rnd read_underflow", 64'(read_underflow), 64'(m_uf));
      chk("rnd write_overflow", 64'(write_overflow), 64'(m_ov));
    end
    idle();
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_port_endpoint.md
Name: io_port_endpoint

Overview:
Device-side endpoint for one Datapath I/O port: the responder to the Datapath's io_rden/io_wren/EF protocol. It buffers words arriving from an external producer and presents them as a readable port. It also accepts words written by the Datapath and drains them to an external consumer over valid/ready. One instance is built per port; a bank of IO_PORT_COUNT instances feeds the Datapath's packed io_read_EF_*/io_read_data_*/io_write_EF_* buses.

Parameters:
WORD_WIDTH, 36, width of a data word.
DEPTH, 4, entries in each of the inbound and outbound FIFOs; must be a power of 2, at least 2.
DEPTH_WIDTH, 2, log2(DEPTH).
RAMSTYLE, "MLAB", storage ramstyle attribute for both FIFOs.

Ports:
clock  input  1  system clock, all logic on rising edge.
reset_n  input  1  synchronous, active-low reset.
io_read_EF  output  1  1 = read word available (Datapath may read).
io_read_data  output  WORD_WIDTH  head of inbound FIFO; valid whenever io_read_EF=1.
io_rden  input  1  Datapath consumes io_read_data this cycle.
io_write_EF  output  1  1 = outbound FIFO full (Datapath must not write).
io_write_data  input  WORD_WIDTH  word written by Datapath.
io_wren  input  1  Datapath writes io_write_data this cycle.
in_valid  input  1  external producer offers in_data.
in_ready  output  1  inbound FIFO can accept.
in_data  input  WORD_WIDTH  external inbound word.
out_valid  output  1  outbound word available.
out_ready  input  1  external consumer accepts out_data.
out_data  output  WORD_WIDTH  head of outbound FIFO.
in_count  output  DEPTH_WIDTH+1  inbound occupancy, 0..DEPTH.
out_count  output  DEPTH_WIDTH+1  outbound occupancy, 0..DEPTH.
read_underflow  output  1  sticky: io_rden seen while io_read_EF=0.
write_overflow  output  1  sticky: io_wren seen while io_write_EF=1.

Behaviour:
- Each FIFO has read and write pointers DEPTH_WIDTH+1 bits wide; the MSB is the wrap bit. Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ. Counts are the pointer difference, registered.
- Both FIFOs are first-word-fall-through. The head word is on io_read_data/out_data in the same cycle the flag asserts. Data is X-free after the first push; before any push the data outputs are 0.
- Flags derive combinationally from registered state:
  - io_read_EF = inbound not empty.
  - in_ready = inbound not full.
  - io_write_EF = outbound full.
  - out_valid = outbound not empty.
- Inbound push on in_valid & in_ready. Inbound pop on io_rden & io_read_EF.
- Outbound push on io_wren & ~io_write_EF. Outbound pop on out_valid & out_ready.
- Latency: a word pushed at edge N is visible at the opposite side after edge N, i.e. 1 cycle.
- Simultaneous push and pop on a non-empty, non-full FIFO: both occur and the count is unchanged.
- Push and pop when full: only the pop occurs. in_ready/io_write_EF are evaluated from pre-edge state, so there is no full-bypass; the count drops by 1.
- Pop and push when empty: only the push occurs. There is no empty-bypass; the word appears next cycle.
- Illegal accesses:
  - io_rden while empty: ignored; pointers unchanged; read_underflow sets.
  - io_wren while full: write discarded; write_overflow sets.
  - Both sticky bits clear only on reset.
- Pointers wrap modulo 2*DEPTH with no special handling.
- Reset (reset_n=0 at a rising edge), including mid-transfer:
  - Pointers, counts and sticky bits go to 0; stored words are dropped.
  - Resulting outputs: io_read_EF=0, io_write_EF=0, in_ready=1, out_valid=0, data outputs 0.
  - All pushes and pops in the reset cycle are ignored.
- The Datapath bench idiom (read EF=0, write EF=1 = not ready) is matched exactly, except that the write EF after reset is 0 because an empty endpoint is writable.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 and io_wren=1 -> in_count=0, out_count=0, io_read_EF=0, io_write_EF=0, in_ready=1, out_valid=0, both sticky bits 0.
- Inbound ordering: push 36'd1, 36'd2, 36'd3 on consecutive cycles, then io_rden for 3 cycles -> io_read_data reads 1, 2, 3 in order; io_read_EF falls after the third pop; in_count goes 1, 2, 3, 2, 1, 0.
- Fill/wrap: push 5 words 10..14 with DEPTH=4 and no reads -> in_ready=0 after the 4th push and 14 is not accepted. Pop 4 then push 20..23 -> reads 20..23, exercising pointer wrap.
- Full simultaneous: outbound full with out_ready=1 and io_wren=1 in the same cycle -> pop only, out_count 4->3, write_overflow=1. Next cycle io_wren is accepted.
- Empty simultaneous: inbound empty with io_rden=1 and in_valid=1 (in_data=36'd7) -> read_underflow=1, in_count=1, io_read_EF=1 next cycle with io_read_data=7.
- Outbound streaming: io_wren every cycle with data 4, 5, 6 and out_ready=1 -> out_data 4, 5, 6 each one cycle after its write; out_count never exceeds 1.
